// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory request/response,
// redirect input, and the decode-side valid/ready output port.
interface fetch_unit_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc, out_instr, out_fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc, out_instr, out_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: issues sequential PCs to a 1-cycle imem,
// queues responses, hands them to decode; redirect flushes/faults.
// Ports: clk, rst (async, active-high), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter int              QDEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;
  localparam logic [AW+1:0] W_DEPTH = (AW+2)'(QDEPTH);

  logic [0:0]      r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_infl_pc;
  logic            r_infl;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [AW:0]     r_cnt;

  logic [XLEN-1:0] r_q_pc    [QDEPTH];
  logic [ILEN-1:0] r_q_instr [QDEPTH];
  logic            r_q_fault [QDEPTH];

  logic            w_redir;
  logic            w_misal;
  logic            w_nonempty;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_req;
  logic [AW+1:0]   w_occ;

  assign w_redir    = bus.redirect_valid;
  assign w_misal    = |bus.redirect_pc[1:0];
  assign w_nonempty = (r_cnt != '0);
  assign w_valid    = w_nonempty & ~w_redir;
  assign w_pop      = w_valid & bus.out_ready;
  assign w_push     = r_infl & ~w_redir;

  // Occupancy after this edge if we issue nothing; the
  // in-flight word already owns a slot.
  assign w_occ = {1'b0, r_cnt}
               + (AW+2)'(r_infl)
               - (AW+2)'(w_pop);

  assign w_req = ~rst & (r_state == S_RUN)
               & ~w_redir & (w_occ < W_DEPTH);

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_pc    = w_nonempty ? r_q_pc[r_rd]    : '0;
  assign bus.out_instr = w_nonempty ? r_q_instr[r_rd] : '0;
  assign bus.out_fault = w_nonempty & r_q_fault[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_fetch_pc <= RESET_PC;
      r_infl_pc  <= '0;
      r_infl     <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
    end else if (w_redir) begin
      r_infl <= 1'b0;
      r_rd   <= '0;
      if (w_misal) begin
        // Single fault entry sits in slot 0.
        r_state <= S_HALT;
        r_wr    <= AW'(1);
        r_cnt   <= (AW+1)'(1);
      end else begin
        r_state    <= S_RUN;
        r_fetch_pc <= bus.redirect_pc;
        r_wr       <= '0;
        r_cnt      <= '0;
      end
    end else begin
      r_infl <= w_req;
      if (w_req) begin
        r_infl_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_redir) begin
      if (w_misal) begin
        r_q_pc[0]    <= bus.redirect_pc;
        r_q_instr[0] <= NOP_INSTR;
        r_q_fault[0] <= 1'b1;
      end
    end else if (w_push) begin
      r_q_pc[r_wr]    <= r_infl_pc;
      r_q_instr[r_wr] <= bus.imem_rdata;
      r_q_fault[r_wr] <= 1'b0;
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised, decoupled instruction fetch stage that replaces the fixed PC+4 fetch loop.
- Generates sequential PCs and issues them to an external 1-cycle-latency instruction memory.
- Buffers returned instructions in a QDEPTH-entry queue.
- Presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap target) with flush, plus a misaligned-target fault halt.

Parameters:
XLEN, 64, PC and address width in bits
ILEN, 32, instruction width in bits
QDEPTH, 4, fetch-queue depth; power of two, >= 2
RESET_PC, 64'h0, PC loaded on reset (XLEN bits)
NOP_INSTR, 32'h00000013, instruction word emitted with a fault entry

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request this cycle
imem_addr  output  XLEN  byte address of request; equals fetch_pc
imem_rdata  input  ILEN  instruction for the request issued in the previous cycle
redirect_valid  input  1  load new PC and flush
redirect_pc  input  XLEN  redirect target
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_pc  output  XLEN  PC of head entry
out_instr  output  ILEN  instruction of head entry
out_fault  output  1  head entry is a misaligned-target fault

Behaviour:
Reset (asynchronous, while rst=1 and on release):
- fetch_pc=RESET_PC; state=RUN; queue empty; inflight=0.
- imem_req=0, out_valid=0, out_pc=0, out_instr=0, out_fault=0.

State machine: RUN, HALT.
- RUN -> HALT: redirect with redirect_pc[1:0]!=0.
- HALT -> RUN: redirect with redirect_pc[1:0]==0.
- Reset -> RUN.

Credit rule (pop = out_valid & out_ready):
- imem_req = (state==RUN) & !redirect_valid & (count + inflight - pop < QDEPTH).

Issue:
- When imem_req=1: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- PC increment wraps modulo 2^XLEN.
- Otherwise inflight<=0.

Response:
- imem_rdata is sampled in the cycle after issue when inflight=1 and redirect_valid=0.
- The pair {inflight_pc, imem_rdata, fault=0} is written at that cycle's edge.
- Latency: req in cycle N -> out_valid in cycle N+2.

Output:
- out_valid = (count!=0) & !redirect_valid.
- out_pc/out_instr/out_fault always reflect the queue head; they hold while out_valid & !out_ready.
- Push and pop in the same cycle are allowed at any occupancy, including full.

Throughput and order:
- 1 instruction/cycle sustained while out_ready=1.
- Queue order is strictly program order.

Redirect (cycle R):
- Queue flushed; inflight response arriving in R discarded; no request in R.
- Aligned target: fetch_pc<=redirect_pc; first request at redirect_pc in R+1; out_valid in R+3.
- Misaligned target: one entry {redirect_pc, NOP_INSTR, fault=1} written at the end of R; state<=HALT.
  - out_valid in R+1.
  - No further imem_req until the next aligned redirect.
- A redirect during HALT or back-to-back redirects: the last one wins, with the same flush rules.
- A redirect concurrent with a pop: the pop is not a handshake, because out_valid is forced low.

Stall:
- out_ready=0 fills the queue to QDEPTH entries.
- imem_req deasserts exactly when count+inflight reaches QDEPTH.
- No entry is lost or duplicated.

Reset mid-operation:
- Aborts everything immediately.
- The first request after release is at RESET_PC.

Test Plan:
- Reset release, out_ready=1, memory word[i]=0x1000+i -> imem_req in cycle 0, addr 0,4,8,...; out_valid from cycle 2; out_pc 0,4,8 with instr 0x1000,0x1001,0x1002 on consecutive cycles.
- out_ready=0 from cycle 2, QDEPTH=4 -> exactly 4 entries queued (PC 0..12); imem_req low afterwards; on out_ready=1, PCs 0,4,8,12,16 emerge with no gap or duplicate.
- Redirect to 0x200 while 3 entries are queued -> out_valid low in R and R+1/R+2; imem_addr=0x200 in R+1; out_pc=0x200 in R+3; old entries never appear.
- Redirect to 0x202 -> out_valid in R+1 with out_pc=0x202, out_instr=0x00000013, out_fault=1; no imem_req; later redirect to 0x300 resumes with out_pc=0x300, fault=0.
- fetch_pc near 2^64-8, sequential fetch -> PCs FFFF...F8, FFFF...FC, 0 in order.
- Assert rst for 1 cycle while the queue is full with a request in flight -> all outputs 0 during rst; after release the first out_pc=RESET_PC.
